seq_window_checker: RTL and testbench

SEQ_WINDOW_CHECKER -- requirements
Module: seq_window_checker

---
 rtl/seq_window_checker.sv | 144 ++++++++++++++
 tb/tb_seq_window_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_window_checker.sv
// seq_window_checker: per-channel "ant |-> ##[MIN_DLY:MAX_DLY] cons" checker
// with saturating fail/pass counters and a sticky first-failure record.
// Optional feature: define SEQ_WINDOW_CHECKER_PASS_CNT_EN to build the pass
// counter; without it pass_cnt is tied to zero and no pass logic exists.
module seq_window_checker #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MIN_DLY = 1,
    parameter int unsigned MAX_DLY = 3,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dis,
    input  logic [NUM_CH-1:0] ant,
    input  logic [NUM_CH-1:0] cons,
    input  logic              clr,
    output logic [NUM_CH-1:0] fail_pulse,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic              busy,
    output logic              first_fail_vld,
    output logic [CH_W-1:0]   first_fail_ch
);

    localparam int unsigned POP_W = $clog2(NUM_CH + 1);
    localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Bit k of a pending vector holds an obligation that will be age k+1 at
    // the next edge, so the discharge window is bits MIN_DLY-1..MAX_DLY-1.
    localparam logic [MAX_DLY-1:0] WIN_MASK = MAX_DLY'({MAX_DLY{1'b1}} << (MIN_DLY - 1));

    logic [NUM_CH-1:0][MAX_DLY-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0]              fail_vec;
    logic [NUM_CH-1:0]              fail_pulse_q;
    logic [CNT_W-1:0]               fail_cnt_q, fail_cnt_d;
    logic                           ffv_q, ffv_d;
    logic [CH_W-1:0]                ffc_q, ffc_d;

    function automatic logic [POP_W-1:0] popcnt(input logic [NUM_CH-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) c = c + POP_W'(v[i]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [POP_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(CNT_MAX)) return CNT_MAX;
        return CNT_W'(s);
    endfunction

    function automatic logic [CH_W-1:0] low_idx(input logic [NUM_CH-1:0] v);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (v[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

    // Age pending obligations, drop discharged ones, detect expiries, inject new ant.
    always_comb begin
        pend_d   = '0;
        fail_vec = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            fail_vec[ch] = pend_q[ch][MAX_DLY-1] & ~cons[ch];
            pend_d[ch]   = MAX_DLY'({(cons[ch] ? (pend_q[ch] & ~WIN_MASK) : pend_q[ch]), ant[ch]});
        end
        if (dis) begin
            pend_d   = '0;
            fail_vec = '0;
        end
    end

    // Failure counter and first-failure capture; clr wins over any update.
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        ffv_d      = ffv_q;
        ffc_d      = ffc_q;
        if (clr) begin
            fail_cnt_d = '0;
            ffv_d      = 1'b0;
            ffc_d      = '0;
        end else begin
            fail_cnt_d = sat_add(fail_cnt_q, popcnt(fail_vec));
            if (!ffv_q && (|fail_vec)) begin
                ffv_d = 1'b1;
                ffc_d = low_idx(fail_vec);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '0;
            fail_pulse_q <= '0;
            fail_cnt_q   <= '0;
            ffv_q        <= 1'b0;
            ffc_q        <= '0;
        end else begin
            pend_q       <= pend_d;
            fail_pulse_q <= fail_vec;
            fail_cnt_q   <= fail_cnt_d;
            ffv_q        <= ffv_d;
            ffc_q        <= ffc_d;
        end
    end

`ifdef SEQ_WINDOW_CHECKER_PASS_CNT_EN
    logic [NUM_CH-1:0] pass_vec;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;

    // A channel passes when cons hits at least one in-window obligation.
    always_comb begin
        pass_vec = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            pass_vec[ch] = cons[ch] & (|(pend_q[ch] & WIN_MASK));
        end
        if (dis) pass_vec = '0;
        pass_cnt_d = clr ? '0 : sat_add(pass_cnt_q, popcnt(pass_vec));
    end

    // Pass counter register.
    always_ff @(posedge clk) begin
        if (rst) pass_cnt_q <= '0;
        else     pass_cnt_q <= pass_cnt_d;
    end

    assign pass_cnt = pass_cnt_q;
`else
    assign pass_cnt = '0;
`endif

    assign fail_pulse     = fail_pulse_q;
    assign fail_cnt       = fail_cnt_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_ch  = ffc_q;
    assign busy           = |pend_q;

endmodule

// File: tb/tb_seq_window_checker.sv
// Self-checking bench for seq_window_checker (NUM_CH=2, window 1..3, CNT_W=2).
module tb_seq_window_checker;

    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned MIN_DLY = 1;
    localparam int unsigned MAX_DLY = 3;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CH_W    = 1;
    localparam int unsigned SNAP_W  = NUM_CH + 2 * CNT_W + 2 + CH_W;
    localparam int          CMAX    = (1 << CNT_W) - 1;
`ifdef SEQ_WINDOW_CHECKER_PASS_CNT_EN
    localparam logic [1:0]  PC1 = 2'd1;
`else
    localparam logic [1:0]  PC1 = 2'd0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              dis = 1'b0;
    logic [NUM_CH-1:0] ant = '0;
    logic [NUM_CH-1:0] cons = '0;
    logic              clr = 1'b0;
    logic [NUM_CH-1:0] fail_pulse;
    logic [CNT_W-1:0]  fail_cnt;
    logic [CNT_W-1:0]  pass_cnt;
    logic              busy;
    logic              first_fail_vld;
    logic [CH_W-1:0]   first_fail_ch;

    int checks = 0;
    int passes = 0;

    // Reference model state: list of outstanding obligations (channel, birth edge).
    int q_ch[$];
    int q_birth[$];
    int tcyc = 0;
    logic [NUM_CH-1:0] m_fp = '0;
    int m_fail_cnt = 0;
    int m_pass_cnt = 0;
    logic m_ffv = 1'b0;
    int m_ffc = 0;

    seq_window_checker #(
        .NUM_CH(NUM_CH), .MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .dis(dis), .ant(ant), .cons(cons), .clr(clr),
        .fail_pulse(fail_pulse), .fail_cnt(fail_cnt), .pass_cnt(pass_cnt),
        .busy(busy), .first_fail_vld(first_fail_vld), .first_fail_ch(first_fail_ch)
    );

    always #5 clk = ~clk;

    function automatic logic [SNAP_W-1:0] obs();
        return {fail_pulse, fail_cnt, pass_cnt, busy, first_fail_vld, first_fail_ch};
    endfunction

    function automatic logic [SNAP_W-1:0] model_snap();
        return {m_fp, CNT_W'(m_fail_cnt), CNT_W'(m_pass_cnt), (q_ch.size() != 0),
                m_ffv, CH_W'(m_ffc)};
    endfunction

    // Apply one rising edge to the model using the inputs present at that edge.
    task automatic model_edge();
        int nch[$];
        int nb[$];
        logic [NUM_CH-1:0] fp;
        logic [NUM_CH-1:0] pv;
        int age;
        fp = '0;
        pv = '0;
        if (rst) begin
            q_ch.delete(); q_birth.delete();
            m_fp = '0; m_fail_cnt = 0; m_pass_cnt = 0; m_ffv = 1'b0; m_ffc = 0;
        end else begin
            if (!dis) begin
                for (int i = 0; i < q_ch.size(); i++) begin
                    age = tcyc - q_birth[i];
                    if (cons[q_ch[i]] && age >= int'(MIN_DLY) && age <= int'(MAX_DLY))
                        pv[q_ch[i]] = 1'b1;
                    else if (age >= int'(MAX_DLY))
                        fp[q_ch[i]] = 1'b1;
                    else begin
                        nch.push_back(q_ch[i]); nb.push_back(q_birth[i]);
                    end
                end
                for (int c = 0; c < int'(NUM_CH); c++) begin
                    if (ant[c]) begin nch.push_back(c); nb.push_back(tcyc); end
                end
                q_ch = nch; q_birth = nb;
            end else begin
                q_ch.delete(); q_birth.delete();
            end
            m_fp = fp;
            if (clr) begin
                m_fail_cnt = 0; m_pass_cnt = 0; m_ffv = 1'b0; m_ffc = 0;
            end else begin
                m_fail_cnt = (m_fail_cnt + $countones(fp) > CMAX) ? CMAX : m_fail_cnt + $countones(fp);
`ifdef SEQ_WINDOW_CHECKER_PASS_CNT_EN
                m_pass_cnt = (m_pass_cnt + $countones(pv) > CMAX) ? CMAX : m_pass_cnt + $countones(pv);
`endif
                if (!m_ffv && fp != '0) begin
                    m_ffv = 1'b1;
                    m_ffc = fp[0] ? 0 : 1;
                end
            end
        end
        tcyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; dis = 1'b0; clr = 1'b0; ant = '0; cons = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [SNAP_W-1:0] exp;
        do_reset();
        exp = '0;
        checks++; if (obs() !== exp) $display("FAIL reset got=%h exp=%h", obs(), exp); else passes++;
    endtask

    task automatic test_pass_window();
        logic [SNAP_W-1:0] exp;
        do_reset();
        ant = 2'b01; tick();
        exp = {2'b00, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0};
        checks++; if (obs() !== exp) $display("FAIL pass_busy got=%h exp=%h", obs(), exp); else passes++;
        ant = 2'b00; tick();
        cons = 2'b01; tick();
        exp = {2'b00, 2'd0, PC1, 1'b0, 1'b0, 1'b0};
        checks++; if (obs() !== exp) $display("FAIL pass_e2 got=%h exp=%h", obs(), exp); else passes++;
        cons = 2'b00; tick();
        checks++; if (obs() !== exp) $display("FAIL pass_after got=%h exp=%h", obs(), exp); else passes++;
    endtask

    task automatic test_fail_timeout();
        logic [SNAP_W-1:0] exp;
        do_reset();
        ant = 2'b10; cons = 2'b10; tick();
        ant = 2'b00; cons = 2'b00; tick(); tick(); tick();
        exp = {2'b10, 2'd1, 2'd0, 1'b0, 1'b1, 1'b1};
        checks++; if (obs() !== exp) $display("FAIL fail_e3 got=%h exp=%h", obs(), exp); else passes++;
        tick();
        exp = {2'b00, 2'd1, 2'd0, 1'b0, 1'b1, 1'b1};
        checks++; if (obs() !== exp) $display("FAIL fail_onecycle got=%h exp=%h", obs(), exp); else passes++;
    endtask

    task automatic test_multi_discharge();
        logic [SNAP_W-1:0] exp;
        do_reset();
        ant = 2'b01; tick(); tick();
        ant = 2'b00; tick();
        cons = 2'b01; tick();
        exp = {2'b00, 2'd0, PC1, 1'b0, 1'b0, 1'b0};
        checks++; if (obs() !== exp) $display("FAIL multi_e3 got=%h exp=%h", obs(), exp); else passes++;
        cons = 2'b00; tick();
        checks++; if (obs() !== exp) $display("FAIL multi_nofail got=%h exp=%h", obs(), exp); else passes++;
    endtask

    task automatic test_disable();
        logic [SNAP_W-1:0] exp;
        do_reset();
        ant = 2'b01; tick();
        ant = 2'b00; dis = 1'b1; tick();
        exp = '0;
        checks++; if (obs() !== exp) $display("FAIL dis_busy got=%h exp=%h", obs(), exp); else passes++;
        dis = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (obs() !== exp) $display("FAIL dis_quiet%0d got=%h exp=%h", i, obs(), exp); else passes++;
        end
    endtask

    task automatic test_saturate_clr();
        logic [SNAP_W-1:0] exp;
        do_reset();
        ant = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        exp = {2'b01, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0};
        checks++; if (obs() !== exp) $display("FAIL sat_mid got=%h exp=%h", obs(), exp); else passes++;
        ant = 2'b00; tick(); tick(); tick();
        exp = {2'b01, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0};
        checks++; if (obs() !== exp) $display("FAIL sat_full got=%h exp=%h", obs(), exp); else passes++;
        clr = 1'b1; tick(); clr = 1'b0;
        exp = '0;
        checks++; if (obs() !== exp) $display("FAIL sat_clr got=%h exp=%h", obs(), exp); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [SNAP_W-1:0] exp;
        do_reset();
        ant = 2'b11; tick();
        ant = 2'b00; tick(); tick(); tick();
        exp = {2'b11, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0};
        checks++; if (obs() !== exp) $display("FAIL both_fail got=%h exp=%h", obs(), exp); else passes++;
        ant = 2'b10; tick();
        ant = 2'b00; tick(); tick();
        clr = 1'b1; tick(); clr = 1'b0;
        exp = {2'b10, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
        checks++; if (obs() !== exp) $display("FAIL clr_vs_fail got=%h exp=%h", obs(), exp); else passes++;
    endtask

    task automatic test_mid_reset();
        logic [SNAP_W-1:0] exp;
        do_reset();
        ant = 2'b11; tick();
        ant = 2'b00; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        exp = '0;
        checks++; if (obs() !== exp) $display("FAIL rst_mid got=%h exp=%h", obs(), exp); else passes++;
        tick();
        checks++; if (obs() !== exp) $display("FAIL rst_e3 got=%h exp=%h", obs(), exp); else passes++;
        tick();
        checks++; if (obs() !== exp) $display("FAIL rst_e4 got=%h exp=%h", obs(), exp); else passes++;
    endtask

    task automatic test_random();
        logic [SNAP_W-1:0] exp;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 63) == 0);
            dis  = ($urandom_range(0, 15) == 0);
            clr  = ($urandom_range(0, 31) == 0);
            ant  = NUM_CH'($urandom_range(0, 3));
            cons = ($urandom_range(0, 2) == 0) ? NUM_CH'($urandom_range(0, 3)) : '0;
            tick();
            exp = model_snap();
            checks++;
            if (obs() !== exp) $display("FAIL rnd cyc=%0d got=%h exp=%h", i, obs(), exp);
            else passes++;
        end
        rst = 1'b0; dis = 1'b0; clr = 1'b0; ant = '0; cons = '0;
    endtask

    initial begin
        test_reset();
        test_pass_window();
        test_fail_timeout();
        test_multi_discharge();
        test_disable();
        test_saturate_clr();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
